// File: rtl/scroll_pkg.sv
`default_nettype none
// ============================================================================
// Module      : scroll_pkg
// Description : Shared FSM encoding, offset width and default timing constants
//               for the message scroll controller.
// Revision    : 1.0 - initial release
// ============================================================================
package scroll_pkg;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_PAUSED = 1'b1
    } state_t;

    localparam int OFFSET_W         = 6;
    localparam int PRESC_W          = 26;
    localparam int DEF_STEP_TICKS   = 25000000;
    localparam int DEF_MSG_LEN      = 16;

endpackage : scroll_pkg
`default_nettype wire

// File: rtl/rise_edge_det.sv
`default_nettype none
// ============================================================================
// Module      : rise_edge_det
// Description : Rising-edge detector on a clean synchronous level. The first
//               clock after reset only loads history, so a level already high
//               at reset release is never reported as an edge.
// Revision    : 1.0 - initial release
// ============================================================================
module rise_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic rise
);

    logic r_hist;
    logic r_armed;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hist  <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_hist  <= in;
            r_armed <= 1'b1;
        end
    end

    assign rise = r_armed & in & ~r_hist;

endmodule : rise_edge_det
`default_nettype wire

// File: rtl/scroll_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : scroll_ctrl
// Description : Pausable scroll-offset generator: a prescaler paces offset
//               steps; a pause button toggles RUN/PAUSED. Optional macro
//               SCROLL_DIR_EN adds btn_dir_clean to reverse scroll direction.
// Revision    : 1.0 - initial release
// ============================================================================
module scroll_ctrl
    import scroll_pkg::*;
#(
    parameter int STEP_TICKS = DEF_STEP_TICKS,
    parameter int MSG_LEN    = DEF_MSG_LEN
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                btn_pause_clean,
`ifdef SCROLL_DIR_EN
    input  logic                btn_dir_clean,
`endif
    output logic                paused,
    output logic                step_tick,
    output logic [OFFSET_W-1:0] offset
);

    localparam logic [PRESC_W-1:0]  c_PRESC_MAX = PRESC_W'(STEP_TICKS - 1);
    localparam logic [OFFSET_W-1:0] c_OFF_MAX   = OFFSET_W'(MSG_LEN - 1);

    state_t                r_state;
    logic [PRESC_W-1:0]    r_presc;
    logic                  r_step;
    logic [OFFSET_W-1:0]   r_offset;
    logic                  w_pause_rise;
    logic                  w_dir_rev;
    logic                  w_presc_wrap;
    logic [OFFSET_W-1:0]   w_offset_next;

    rise_edge_det u_pause_edge (
        .clk  (clk),
        .rst  (rst),
        .in   (btn_pause_clean),
        .rise (w_pause_rise)
    );

`ifdef SCROLL_DIR_EN
    logic w_dir_rise;
    logic r_dir_rev;

    rise_edge_det u_dir_edge (
        .clk  (clk),
        .rst  (rst),
        .in   (btn_dir_clean),
        .rise (w_dir_rise)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dir_rev <= 1'b0;
        end else if (w_dir_rise) begin
            r_dir_rev <= ~r_dir_rev;
        end
    end

    assign w_dir_rev = r_dir_rev;
`else
    assign w_dir_rev = 1'b0;
`endif

    assign w_presc_wrap = (r_presc == c_PRESC_MAX);

    // Wrap by comparison at the ends of the range so offset can never escape it.
    always_comb begin
        w_offset_next = r_offset;
        if (w_dir_rev) begin
            w_offset_next = (r_offset == '0) ? c_OFF_MAX : r_offset - 1'b1;
        end else begin
            w_offset_next = (r_offset == c_OFF_MAX) ? '0 : r_offset + 1'b1;
        end
    end

    // A pause edge on the wrap cycle still lets the step land before freezing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_RUN;
            r_presc  <= '0;
            r_step   <= 1'b0;
            r_offset <= '0;
        end else begin
            r_step <= 1'b0;
            case (r_state)
                ST_RUN: begin
                    if (w_presc_wrap) begin
                        r_presc  <= '0;
                        r_step   <= 1'b1;
                        r_offset <= w_offset_next;
                    end else begin
                        r_presc <= r_presc + 1'b1;
                    end
                    if (w_pause_rise) begin
                        r_state <= ST_PAUSED;
                    end
                end
                ST_PAUSED: begin
                    if (w_pause_rise) begin
                        r_state <= ST_RUN;
                    end
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    assign paused    = (r_state == ST_PAUSED);
    assign step_tick = r_step;
    assign offset    = r_offset;

endmodule : scroll_ctrl
`default_nettype wire

// File: tb/tb_scroll_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_scroll_ctrl
// Description : Self-checking bench for scroll_ctrl (STEP_TICKS=4, MSG_LEN=5)
//               against a run-time based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scroll_ctrl;

    localparam int STEP = 4;
    localparam int MSG  = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_pause_clean = 1'b0;
`ifdef SCROLL_DIR_EN
    logic       btn_dir_clean = 1'b0;
`endif
    logic       paused;
    logic       step_tick;
    logic [5:0] offset;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: elapsed RUN cycles decide when steps happen.
    int m_run_cycles;
    int m_offset;
    bit m_paused, m_step, m_dir;
    bit m_p_hist, m_p_armed, m_d_hist, m_d_armed;

    scroll_ctrl #(
        .STEP_TICKS (STEP),
        .MSG_LEN    (MSG)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .btn_pause_clean (btn_pause_clean),
`ifdef SCROLL_DIR_EN
        .btn_dir_clean   (btn_dir_clean),
`endif
        .paused          (paused),
        .step_tick       (step_tick),
        .offset          (offset)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic model_reset();
        m_run_cycles = 0;
        m_offset     = 0;
        m_paused     = 1'b0;
        m_step       = 1'b0;
        m_dir        = 1'b0;
        m_p_hist     = 1'b0;
        m_p_armed    = 1'b0;
        m_d_hist     = 1'b0;
        m_d_armed    = 1'b0;
    endtask

    task automatic tick();
        bit p_rise, d_rise;
        bit d_in;
        @(posedge clk);
`ifdef SCROLL_DIR_EN
        d_in = btn_dir_clean;
`else
        d_in = 1'b0;
`endif
        if (!rst) begin
            model_reset();
        end else begin
            p_rise    = m_p_armed && btn_pause_clean && !m_p_hist;
            d_rise    = m_d_armed && d_in && !m_d_hist;
            m_p_hist  = btn_pause_clean;
            m_d_hist  = d_in;
            m_p_armed = 1'b1;
            m_d_armed = 1'b1;
            m_step    = 1'b0;
            if (!m_paused) begin
                m_run_cycles++;
                if (m_run_cycles % STEP == 0) begin
                    m_step   = 1'b1;
                    m_offset = m_dir ? (m_offset + MSG - 1) % MSG : (m_offset + 1) % MSG;
                end
            end
            if (p_rise) m_paused = !m_paused;
            if (d_rise) m_dir = !m_dir;
        end
        #1;
    endtask

    task automatic pulse_pause();
        btn_pause_clean = 1'b1;
        tick();
        btn_pause_clean = 1'b0;
    endtask

    task automatic test_reset();
        model_reset();
        #2;
        n_checks++;
        if (paused !== 1'b0 || step_tick !== 1'b0 || offset !== 6'd0)
            $display("FAIL reset_async: got paused=%b step=%b offset=%0d, want 0/0/0", paused, step_tick, offset);
        else n_pass++;
        tick();
        tick();
        n_checks++;
        if (paused !== 1'b0 || step_tick !== 1'b0 || offset !== 6'd0)
            $display("FAIL reset_held: got paused=%b step=%b offset=%0d, want 0/0/0", paused, step_tick, offset);
        else n_pass++;
        rst = 1'b1;
    endtask

    task automatic test_run();
        for (int i = 1; i <= 25; i++) begin
            tick();
            n_checks++;
            if (step_tick !== ((i % STEP) == 0) || offset !== 6'((i / STEP) % MSG))
                $display("FAIL run_cycle%0d: got step=%b offset=%0d, want step=%b offset=%0d",
                         i, step_tick, offset, (i % STEP) == 0, (i / STEP) % MSG);
            else n_pass++;
        end
    endtask

    task automatic test_pause();
        int held_off;
        for (int i = 0; i < 8 && (m_run_cycles % STEP) != 1; i++) tick();
        held_off = m_offset;
        pulse_pause();
        n_checks++;
        if (paused !== 1'b1 || step_tick !== 1'b0)
            $display("FAIL pause_enter: got paused=%b step=%b, want 1/0", paused, step_tick);
        else n_pass++;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_checks++;
            if (paused !== 1'b1 || step_tick !== 1'b0 || offset !== 6'(held_off))
                $display("FAIL pause_hold%0d: got paused=%b step=%b offset=%0d, want 1/0/%0d",
                         i, paused, step_tick, offset, held_off);
            else n_pass++;
        end
        pulse_pause();
        n_checks++;
        if (paused !== 1'b0 || step_tick !== 1'b0)
            $display("FAIL pause_resume: got paused=%b step=%b, want 0/0", paused, step_tick);
        else n_pass++;
        tick();
        n_checks++;
        if (step_tick !== 1'b0)
            $display("FAIL resume_mid1: got step=%b, want 0", step_tick);
        else n_pass++;
        tick();
        n_checks++;
        if (step_tick !== 1'b1 || offset !== 6'((held_off + 1) % MSG))
            $display("FAIL resume_step: got step=%b offset=%0d, want 1/%0d",
                     step_tick, offset, (held_off + 1) % MSG);
        else n_pass++;
    endtask

    task automatic test_pause_on_step();
        int prev_off;
        for (int i = 0; i < 8 && (m_run_cycles % STEP) != STEP - 1; i++) tick();
        prev_off = m_offset;
        pulse_pause();
        n_checks++;
        if (step_tick !== 1'b1 || paused !== 1'b1 || offset !== 6'((prev_off + 1) % MSG))
            $display("FAIL pause_on_step: got step=%b paused=%b offset=%0d, want 1/1/%0d",
                     step_tick, paused, offset, (prev_off + 1) % MSG);
        else n_pass++;
        tick();
        pulse_pause();
        n_checks++;
        if (paused !== 1'b0 || step_tick !== 1'b0)
            $display("FAIL unpause_after_step: got paused=%b step=%b, want 0/0", paused, step_tick);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int guard = 0;
        while (!(m_offset == 3 && (m_run_cycles % STEP) == 1) && guard < 100) begin
            tick();
            guard++;
        end
        pulse_pause();
        n_checks++;
        if (paused !== 1'b1 || offset !== 6'd3)
            $display("FAIL reset_mid_setup: got paused=%b offset=%0d, want 1/3", paused, offset);
        else n_pass++;
        rst = 1'b0;
        model_reset();
        #2;
        n_checks++;
        if (paused !== 1'b0 || step_tick !== 1'b0 || offset !== 6'd0)
            $display("FAIL reset_mid_async: got paused=%b step=%b offset=%0d, want 0/0/0", paused, step_tick, offset);
        else n_pass++;
        tick();
        rst = 1'b1;
        for (int i = 1; i <= STEP; i++) begin
            tick();
            n_checks++;
            if (step_tick !== (i == STEP) || offset !== 6'(i == STEP ? 1 : 0))
                $display("FAIL reset_mid_first_step%0d: got step=%b offset=%0d, want %b/%0d",
                         i, step_tick, offset, i == STEP, i == STEP ? 1 : 0);
            else n_pass++;
        end
    endtask

    task automatic test_held_button();
        btn_pause_clean = 1'b1;
        rst = 1'b0;
        model_reset();
        tick();
        tick();
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (paused !== 1'b0)
                $display("FAIL held_at_release%0d: got paused=%b, want 0", i, paused);
            else n_pass++;
        end
        btn_pause_clean = 1'b0;
        tick();
        pulse_pause();
        n_checks++;
        if (paused !== 1'b1)
            $display("FAIL held_then_press: got paused=%b, want 1", paused);
        else n_pass++;
        pulse_pause();
    endtask

`ifdef SCROLL_DIR_EN
    task automatic test_dir();
        int exp_seq[3] = '{0, 4, 3};
        int guard = 0;
        while (!(m_offset == 1 && !m_step) && guard < 60) begin
            tick();
            guard++;
        end
        btn_dir_clean = 1'b1;
        tick();
        btn_dir_clean = 1'b0;
        for (int k = 0; k < 3; k++) begin
            guard = 0;
            do begin
                tick();
                guard++;
            end while (step_tick !== 1'b1 && guard < 2 * STEP);
            n_checks++;
            if (step_tick !== 1'b1 || offset !== 6'(exp_seq[k]))
                $display("FAIL dir_step%0d: got step=%b offset=%0d, want 1/%0d", k, step_tick, offset, exp_seq[k]);
            else n_pass++;
        end
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) btn_pause_clean = ~btn_pause_clean;
`ifdef SCROLL_DIR_EN
            if ($urandom_range(0, 7) == 0) btn_dir_clean = ~btn_dir_clean;
`endif
            if (!rst) rst = 1'b1;
            else if ($urandom_range(0, 99) == 0) begin
                rst = 1'b0;
                model_reset();
            end
            tick();
            n_checks++;
            if (paused !== m_paused || step_tick !== m_step || offset !== 6'(m_offset))
                $display("FAIL random%0d: got paused=%b step=%b offset=%0d, want %b/%b/%0d",
                         i, paused, step_tick, offset, m_paused, m_step, m_offset);
            else n_pass++;
        end
        rst = 1'b1;
    endtask

    initial begin
        test_reset();
        test_run();
        test_pause();
        test_pause_on_step();
        test_reset_mid();
        test_held_button();
`ifdef SCROLL_DIR_EN
        test_dir();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_scroll_ctrl
`default_nettype wire

// File: doc/scroll_ctrl.md
SCROLL_CTRL -- requirements
Module: scroll_ctrl

Interface
REQ-001 Parameter STEP_TICKS, default 25000000, SHALL be the clk cycles per scroll step (0.5 s at 50 MHz); legal range 2..2^26-1.
REQ-002 Parameter MSG_LEN, default 16, SHALL be the number of character positions in the message; legal range 2..64.
REQ-003 Port clk, input, 1, SHALL be the single 50 MHz clock; all state on its rising edge.
REQ-004 Port rst, input, 1, SHALL be the reset: asynchronous, active-low.
REQ-005 Port btn_pause_clean, input, 1, SHALL be the debounced pause level (1 = pressed), synchronous to clk.
REQ-006 Port paused, output, 1, SHALL be 1 while scrolling is frozen.
REQ-007 Port step_tick, output, 1, SHALL be a one-cycle pulse marking each offset update.
REQ-008 Port offset, output, 6, SHALL be the current leftmost character index, 0..MSG_LEN-1.

Function
REQ-009 The block SHALL have FSM states RUN and PAUSED; RUN after reset.
REQ-010 A rising edge of btn_pause_clean (1 now, 0 previous cycle) SHALL toggle RUN<->PAUSED on the next clk edge; held level and falling edge SHALL cause no transition.
REQ-011 paused SHALL be registered and equal 1 exactly when the state is PAUSED.
REQ-012 In RUN the prescaler SHALL count 0..STEP_TICKS-1 and wrap to 0; in PAUSED it SHALL hold its value, so resume continues mid-interval.
REQ-013 step_tick SHALL be 1 for exactly the one cycle after the prescaler is at STEP_TICKS-1 in RUN; never in PAUSED.
REQ-014 offset SHALL update in the same cycle step_tick is asserted: offset = offset+1, with MSG_LEN-1 wrapping to 0.
REQ-015 offset SHALL never leave 0..MSG_LEN-1; arithmetic SHALL compare against MSG_LEN-1 before incrementing, no modulo operator.
REQ-016 If a rising pause edge arrives in the cycle the prescaler is at STEP_TICKS-1 in RUN, the step SHALL complete (step_tick, offset update) and the state SHALL enter PAUSED in the same edge.
REQ-017 A rising pause edge in PAUSED coincident with any prescaler value SHALL resume with no step that cycle.

Reset
REQ-018 Asserting rst (low) SHALL immediately force state RUN, paused 0, step_tick 0, offset 0, prescaler 0, edge-detect history 0, independent of clk.
REQ-019 Reset mid-operation SHALL discard any in-progress interval; the first step after release SHALL occur STEP_TICKS cycles after the first clk edge with rst high.
REQ-020 A button already held at reset release SHALL NOT be a rising edge (history cleared to 0 gives an edge; therefore history SHALL load btn_pause_clean on the first edge after release and edge detect SHALL be suppressed that cycle).

Configuration
REQ-021 Macro SCROLL_DIR_EN defined: input btn_dir_clean (1 bit) SHALL exist; each rising edge toggles direction; reverse steps SHALL decrement offset, 0 wrapping to MSG_LEN-1; direction resets to forward.
REQ-022 Macro SCROLL_DIR_EN undefined: port btn_dir_clean SHALL be absent and direction fixed forward.

Structure
REQ-023 Package scroll_pkg SHALL hold the FSM state encoding (RUN=1'b0, PAUSED=1'b1), OFFSET_W=6 and the default STEP_TICKS/MSG_LEN constants.
REQ-024 One sub-module, rise_edge_det (clk, rst, in, rise), SHALL implement registered rising-edge detection with the REQ-020 suppression; instantiated once for pause, and once more under SCROLL_DIR_EN.
REQ-025 The prescaler SHALL be local to scroll_ctrl (needs a hold enable).

Verification (STEP_TICKS=4, MSG_LEN=5)
REQ-026 Release reset, no button, run 25 cycles -> step_tick every 4th cycle, offset 0,1,2,3,4,0,1.
REQ-027 Pulse pause at prescaler=1, hold 10 cycles, pulse again -> paused 1 during the hold, offset frozen, next step 2 cycles after resume.
REQ-028 Pause edge in the prescaler=3 cycle -> step_tick pulses, offset increments, paused 1 on the same edge.
REQ-029 Assert rst mid-interval with offset=3 and paused=1 -> outputs 0 at once without clk; first step 4 cycles after release.
REQ-030 Button held high through reset release -> no toggle; paused stays 0 until release and new press.
REQ-031 With SCROLL_DIR_EN: dir edge at offset=1 -> offsets 0,4,3 on successive steps.
